// File: rtl/convertor_pkg.sv
// Shared types for the convertor APB requester: bus widths, FSM states
// and the queued command record.
package convertor_pkg;

    localparam int ADDR_WIDTH = 2;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/convertor_cmd_fifo.sv
// Synchronous command FIFO feeding the APB sequencer; depth must be a
// power of two so the pointers wrap naturally.
module convertor_cmd_fifo
    import convertor_pkg::*;
#(
    parameter  int QUEUE_DEPTH = 2,
    localparam int PTR_W       = $clog2(QUEUE_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  apb_cmd_t         wr_data,
    input  logic             pop,
    output apb_cmd_t         rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    apb_cmd_t         mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(QUEUE_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/convertor_apb_master.sv
// APB requester: queues commands and sequences SETUP/ACCESS phases.
// Optional ACCESS-phase abort on stalled pready: define APB_TIMEOUT_EN.
module convertor_apb_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int QUEUE_DEPTH    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    import convertor_pkg::*;

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    // The queued record is sized by the package widths.
    if (ADDR_WIDTH != convertor_pkg::ADDR_WIDTH ||
        DATA_WIDTH != convertor_pkg::DATA_WIDTH ||
        QUEUE_DEPTH < 2 ||
        (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("convertor_apb_master: bad parameters");
    end

    apb_state_e       state;
    apb_state_e       state_nx;
    apb_cmd_t         cmd_in;
    apb_cmd_t         head;
    apb_cmd_t         next_cmd;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             pending;
    logic             done;
    logic             expired;

    assign cmd_ready = (count < CNT_W'(QUEUE_DEPTH));
    assign push      = cmd_valid && !full;
    assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    // An empty queue lets this cycle's command start SETUP straight away.
    assign pending   = !empty || push;
    assign next_cmd  = empty ? cmd_in : head;

    convertor_cmd_fifo #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] wait_cnt;

    assign expired = (state == ACCESS) && !pready &&
                     (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_nx == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rsp_err <= 1'b0;
        else       rsp_err <= expired;
    end
`else
    assign expired = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) state_nx = SETUP;
            end
            SETUP: begin
                pop      = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done     = 1'b1;
                    state_nx = pending ? SETUP : IDLE;
                end else if (expired) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign psel    = (state != IDLE);
    assign penable = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (reset) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done || expired;
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
            end else if (expired) begin
                rsp_rdata <= '0;
            end
            if (state_nx == SETUP) begin
                paddr  <= next_cmd.addr;
                pwrite <= next_cmd.write;
                pwdata <= next_cmd.wdata;
            end
        end
    end

endmodule
